cve2_rf_wb_arbiter: RTL and testbench

//  Drives the single register-file write port (waddr/wdata/we) from two producers: ALU/CSR

---
 rtl/cve2_rf_wb_arbiter_if.sv | 43 ++++
 rtl/cve2_rf_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cve2_rf_wb_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cve2_rf_wb_arbiter_if.sv
// Register-file writeback arbiter bus: ALU/CSR results, LSU load
// issue/response, ID hazard query and the RF write port.
interface cve2_rf_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 alu_we_i;
  logic [4:0]           alu_waddr_i;
  logic [DataWidth-1:0] alu_wdata_i;
  logic                 lsu_issue_i;
  logic [4:0]           lsu_issue_rd_i;
  logic                 lsu_issue_ready_o;
  logic                 lsu_rvalid_i;
  logic [DataWidth-1:0] lsu_rdata_i;
  logic                 lsu_err_i;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic [4:0]           id_rd_i;
  logic                 hazard_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;
  logic                 idle_o;

  modport slave (
    input  alu_we_i, alu_waddr_i, alu_wdata_i,
    input  lsu_issue_i, lsu_issue_rd_i,
    input  lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    input  raddr_a_i, raddr_b_i, id_rd_i,
    output lsu_issue_ready_o, hazard_o,
    output rf_waddr_o, rf_wdata_o, rf_we_o,
    output idle_o
  );

  modport master (
    output alu_we_i, alu_waddr_i, alu_wdata_i,
    output lsu_issue_i, lsu_issue_rd_i,
    output lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    output raddr_a_i, raddr_b_i, id_rd_i,
    input  lsu_issue_ready_o, hazard_o,
    input  rf_waddr_o, rf_wdata_o, rf_we_o,
    input  idle_o
  );
endinterface

// File: rtl/cve2_rf_wb_arbiter.sv
// Single RF write port shared by ALU results and in-order loads,
// with a load slot ring and a busy scoreboard for ID hazards.
module cve2_rf_wb_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LoadDepth = 2
) (
  input logic clk_i,
  input logic rst_ni,
  cve2_rf_wb_arbiter_if.slave bus
);
  localparam int unsigned PW =
    (LoadDepth > 1) ? $clog2(LoadDepth) : 1;
  localparam int unsigned CW = $clog2(LoadDepth + 1);

  typedef enum logic [1:0] {
    SlotEmpty,
    SlotWait,
    SlotData
  } slot_e;
  typedef logic [PW-1:0] ptr_t;

  slot_e                st_q   [LoadDepth];
  slot_e                st_d   [LoadDepth];
  logic [4:0]           rd_q   [LoadDepth];
  logic [4:0]           rd_d   [LoadDepth];
  logic [DataWidth-1:0] data_q [LoadDepth];
  logic [DataWidth-1:0] data_d [LoadDepth];
  ptr_t                 head_q, head_d;
  ptr_t                 tail_q, tail_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic ready, issue, resp, head_resp, retire;
  logic wait_hit, alu_busy;
  ptr_t wait_idx;

  function automatic logic rd_ok(logic [4:0] r);
    return (r != 5'd0) && !(RV32E && r[4]);
  endfunction

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(LoadDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Responses are in order: they belong to the oldest WAIT slot.
  always_comb begin
    ptr_t idx;
    idx      = '0;
    wait_hit = 1'b0;
    wait_idx = '0;
    for (int i = 0; i < int'(LoadDepth); i++) begin
      idx = ptr_t'((int'(head_q) + i) % int'(LoadDepth));
      if (!wait_hit && st_q[idx] == SlotWait) begin
        wait_hit = 1'b1;
        wait_idx = idx;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    rd_d   = rd_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    retire = 1'b0;
    bus.rf_we_o    = 1'b0;
    bus.rf_waddr_o = '0;
    bus.rf_wdata_o = '0;

    ready     = cnt_q < CW'(LoadDepth);
    issue     = bus.lsu_issue_i && ready;
    resp      = bus.lsu_rvalid_i && wait_hit;
    head_resp = resp && (wait_idx == head_q);

    if (resp) begin
      st_d[wait_idx]   = bus.lsu_err_i ? SlotEmpty : SlotData;
      data_d[wait_idx] = bus.lsu_rdata_i;
    end

    if (bus.alu_we_i) begin
      bus.rf_we_o    = rd_ok(bus.alu_waddr_i);
      bus.rf_waddr_o = bus.alu_waddr_i;
      bus.rf_wdata_o = bus.alu_wdata_i;
    end else if (st_q[head_q] == SlotData) begin
      bus.rf_we_o    = rd_ok(rd_q[head_q]);
      bus.rf_waddr_o = rd_q[head_q];
      bus.rf_wdata_o = data_q[head_q];
      retire         = 1'b1;
    end else if (head_resp && !bus.lsu_err_i) begin
      bus.rf_we_o    = rd_ok(rd_q[head_q]);
      bus.rf_waddr_o = rd_q[head_q];
      bus.rf_wdata_o = bus.lsu_rdata_i;
      retire         = 1'b1;
    end

    // Faulted slots retire without the port, even under ALU traffic.
    if (head_resp && bus.lsu_err_i) retire = 1'b1;
    if (st_q[head_q] == SlotEmpty && cnt_q != '0) retire = 1'b1;

    if (retire) begin
      st_d[head_q] = SlotEmpty;
      head_d       = ptr_inc(head_q);
    end
    if (issue) begin
      st_d[tail_q] = SlotWait;
      rd_d[tail_q] = bus.lsu_issue_rd_i;
      tail_d       = ptr_inc(tail_q);
    end
    cnt_d = cnt_q + CW'(issue) - CW'(retire);

    bus.lsu_issue_ready_o = ready;
    bus.idle_o            = (cnt_q == '0);
  end

  always_comb begin
    bus.hazard_o = 1'b0;
    alu_busy     = 1'b0;
    for (int i = 0; i < int'(LoadDepth); i++) begin
      if (st_q[i] != SlotEmpty && rd_ok(rd_q[i])) begin
        if (rd_q[i] == bus.raddr_a_i ||
            rd_q[i] == bus.raddr_b_i ||
            rd_q[i] == bus.id_rd_i)
          bus.hazard_o = 1'b1;
        if (rd_q[i] == bus.alu_waddr_i)
          alu_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(LoadDepth); i++) begin
        st_q[i]   <= SlotEmpty;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  a_rvalid_pending: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.lsu_rvalid_i |-> wait_hit
  ) else $error("load response with no pending load");

  a_alu_not_busy: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.alu_we_i |-> !alu_busy
  ) else $error("ALU write to a register with a pending load");
endmodule

// File: tb/tb_cve2_rf_wb_arbiter.sv
// Randomized and directed bench for cve2_rf_wb_arbiter against
// a queue model of outstanding loads.
module tb_cve2_rf_wb_arbiter;
  localparam int Depth = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  cve2_rf_wb_arbiter_if #(.DataWidth(32)) bus ();

  cve2_rf_wb_arbiter #(
    .RV32E(1'b0), .DataWidth(32), .LoadDepth(Depth)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus)
  );

  // st: 0 waiting, 1 data held, 2 faulted (dead)
  typedef struct {
    logic [4:0]  rd;
    int          st;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  int n_chk = 0;
  int n_err = 0;

  logic        obs_we, obs_haz, obs_rdy, obs_idl;
  logic [4:0]  obs_wa;
  logic [31:0] obs_wd;

  task automatic check(string tag, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic bit vrd(logic [4:0] r);
    return r != 5'd0;
  endfunction

  function automatic bit mbusy(logic [4:0] r);
    if (!vrd(r)) return 1'b0;
    foreach (q[i]) if (q[i].st != 2 && q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit has_wait();
    foreach (q[i]) if (q[i].st == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_idle();
    bus.alu_we_i = 0; bus.alu_waddr_i = 0; bus.alu_wdata_i = 0;
    bus.lsu_issue_i = 0; bus.lsu_issue_rd_i = 0;
    bus.lsu_rvalid_i = 0; bus.lsu_rdata_i = 0; bus.lsu_err_i = 0;
    bus.raddr_a_i = 0; bus.raddr_b_i = 0; bus.id_rd_i = 0;
  endtask

  task automatic step(bit awe, logic [4:0] awa, logic [31:0] awd,
                      bit iss, logic [4:0] ird,
                      bit rv, logic [31:0] rdat, bit er,
                      logic [4:0] ra, logic [4:0] rb,
                      logic [4:0] idr);
    int wi, sz;
    bit hw, pop, ew;
    logic [4:0] ewa;
    logic [31:0] ewd;
    ent_t e;
    bus.alu_we_i = awe; bus.alu_waddr_i = awa;
    bus.alu_wdata_i = awd;
    bus.lsu_issue_i = iss; bus.lsu_issue_rd_i = ird;
    bus.lsu_rvalid_i = rv; bus.lsu_rdata_i = rdat;
    bus.lsu_err_i = er;
    bus.raddr_a_i = ra; bus.raddr_b_i = rb; bus.id_rd_i = idr;
    #1;
    wi = -1;
    foreach (q[i]) if (wi < 0 && q[i].st == 0) wi = i;
    sz = q.size();
    hw = sz > 0 && q[0].st == 0 && rv;
    ew = 0; ewa = 0; ewd = 0; pop = 0;
    if (awe) begin
      ew = vrd(awa); ewa = awa; ewd = awd;
    end else if (sz > 0 && q[0].st == 1) begin
      ew = vrd(q[0].rd); ewa = q[0].rd; ewd = q[0].d; pop = 1;
    end else if (hw && !er) begin
      ew = vrd(q[0].rd); ewa = q[0].rd; ewd = rdat; pop = 1;
    end
    if (hw && er) pop = 1;
    if (sz > 0 && q[0].st == 2) pop = 1;

    obs_we = bus.rf_we_o; obs_wa = bus.rf_waddr_o;
    obs_wd = bus.rf_wdata_o; obs_haz = bus.hazard_o;
    obs_rdy = bus.lsu_issue_ready_o; obs_idl = bus.idle_o;
    check("we", obs_we, ew);
    if (ew) begin
      check("waddr", obs_wa, ewa);
      check("wdata", obs_wd, ewd);
    end
    check("hazard", obs_haz, mbusy(ra) | mbusy(rb) | mbusy(idr));
    check("ready", obs_rdy, sz < Depth);
    check("idle", obs_idl, sz == 0);

    if (rv && wi >= 0) begin
      q[wi].st = er ? 2 : 1;
      q[wi].d  = rdat;
    end
    if (pop) void'(q.pop_front());
    if (iss && sz < Depth) begin
      e.rd = ird; e.st = 0; e.d = 0;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic nop(logic [4:0] ra);
    step(0, 0, 0, 0, 0, 0, 0, 0, ra, 0, 0);
  endtask

  task automatic ld(logic [4:0] rd);
    step(0, 0, 0, 1, rd, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit awe, iss, rv, er;
    logic [4:0] awa;
    drive_idle();
    #2;
    check("rst_we", bus.rf_we_o, 0);
    check("rst_waddr", bus.rf_waddr_o, 0);
    check("rst_wdata", bus.rf_wdata_o, 0);
    check("rst_hazard", bus.hazard_o, 0);
    check("rst_idle", bus.idle_o, 1);
    check("rst_ready", bus.lsu_issue_ready_o, 1);
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;

    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_we", obs_we, 1);
    check("t1_waddr", obs_wa, 5);
    check("t1_wdata", obs_wd, 32'hDEADBEEF);
    step(1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_x0", obs_we, 0);

    step(0, 0, 0, 1, 7, 0, 0, 0, 7, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h1234, 0, 7, 0, 0);
    check("t2_haz", obs_haz, 1);
    check("t2_we", obs_we, 1);
    check("t2_waddr", obs_wa, 7);
    check("t2_wdata", obs_wd, 32'h1234);
    nop(7);
    check("t2_haz_clr", obs_haz, 0);
    check("t2_idle", obs_idl, 1);

    ld(3);
    step(1, 9, 32'h99, 0, 0, 1, 32'hA5, 0, 3, 0, 0);
    check("t3_alu", obs_wa, 9);
    nop(3);
    check("t3_haz", obs_haz, 1);
    check("t3_waddr", obs_wa, 3);
    check("t3_wdata", obs_wd, 32'hA5);
    nop(3);
    check("t3_clr", obs_haz, 0);

    ld(1);
    ld(2);
    ld(8);
    check("t4_full", obs_rdy, 0);
    step(0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 0);
    check("t4_w1", obs_wa, 1);
    check("t4_d1", obs_wd, 32'h11);
    step(0, 0, 0, 0, 0, 1, 32'h22, 0, 0, 0, 0);
    check("t4_rdy", obs_rdy, 1);
    check("t4_w2", obs_wa, 2);
    check("t4_d2", obs_wd, 32'h22);
    nop(0);
    check("t4_idle", obs_idl, 1);

    for (int k = 0; k < 10; k++) begin
      ld(4);
      ld(6);
      step(0, 0, 0, 0, 0, 1, 32'h44, 1, 4, 0, 0);
      check("t5_nowr", obs_we, 0);
      step(0, 0, 0, 0, 0, 1, 32'h66, 0, 4, 0, 0);
      check("t5_clr4", obs_haz, 0);
      check("t5_w6", obs_wa, 6);
      nop(6);
      check("t5_haz6", obs_haz, 0);
    end

    for (int k = 0; k < 3000; k++) begin
      awa = 5'($urandom);
      awe = ($urandom % 3 == 0) && !mbusy(awa);
      iss = $urandom % 2;
      rv  = has_wait() && ($urandom % 2);
      er  = ($urandom % 5 == 0);
      step(awe, awa, $urandom, iss, 5'($urandom), rv, $urandom,
           er, 5'($urandom), 5'($urandom), 5'($urandom));
    end
    while (q.size() > 0 && has_wait())
      step(0, 0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0);
    repeat (3) nop(0);
    check("rand_idle", obs_idl, 1);

    ld(10);
    ld(11);
    drive_idle();
    bus.raddr_a_i = 10;
    #2;
    check("t6_pend", bus.hazard_o, 1);
    rst_ni = 1'b0;
    #1;
    check("t6_idle", bus.idle_o, 1);
    check("t6_haz", bus.hazard_o, 0);
    check("t6_we", bus.rf_we_o, 0);
    check("t6_rdy", bus.lsu_issue_ready_o, 1);
    q.delete();
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;
    nop(10);
    check("t6_post_idle", obs_idl, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
